// File: rtl/bshift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// the pipeline-depth helper used by barrel_shift_pipe.
package bshift_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Number of pipeline registers: one per REG_EVERY mux levels, plus the tail.
  function automatic int num_stages(input int shamt_w, input int reg_every);
    return (shamt_w + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/bshift_stage.sv
// One mux level of the barrel shifter: shifts by DIST when enabled.
// BSHIFT_STICKY_EN adds the OR of the bits discarded at this level.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_fill,
  input  logic             i_en,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_data
`ifdef BSHIFT_STICKY_EN
  ,
  output logic             o_sticky
`endif
);

  logic [WIDTH-1:0] w_sh;
  logic             w_top;

  // Only SRA replicates the sign; SRL shares the same datapath with zero fill.
  assign w_top = (i_op == OP_SRA) && i_fill;

  always_comb begin
    w_sh = i_data;
    case (i_op)
      OP_SLL:         w_sh = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
      OP_SRL, OP_SRA: w_sh = {{DIST{w_top}}, i_data[WIDTH-1:DIST]};
      OP_ROR:         w_sh = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
      default:        w_sh = i_data;
    endcase
  end

  assign o_data = i_en ? w_sh : i_data;

`ifdef BSHIFT_STICKY_EN
  logic w_lost;

  always_comb begin
    w_lost = 1'b0;
    case (i_op)
      OP_SLL:         w_lost = |i_data[WIDTH-1 -: DIST];
      OP_SRL, OP_SRA: w_lost = |i_data[DIST-1:0];
      default:        w_lost = 1'b0;
    endcase
  end

  assign o_sticky = i_en && w_lost;
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready and a global stall.
// Optional out_sticky (OR of shifted-out bits) under macro BSHIFT_STICKY_EN.
module barrel_shift_pipe
  import bshift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHAMT_W   = $clog2(WIDTH),
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [OP_W-1:0]    in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef BSHIFT_STICKY_EN
  ,
  output logic               out_sticky
`endif
);

  localparam int L = num_stages(SHAMT_W, REG_EVERY);

  logic         w_adv;
  logic         w_acc;
  logic [L:1]   vld_pipe;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && !rst;
  assign w_acc    = in_valid && in_ready;

  // Bubbles shift through as zeros; nothing is compressed.
  always_ff @(posedge clk or posedge rst)
    if (rst)        vld_pipe <= '0;
    else if (w_adv) vld_pipe <= L'({vld_pipe, w_acc});

  for (genvar g = 0; g < L; g++) begin : grp
    localparam int K0 = g * REG_EVERY;
    localparam int K1 = ((g + 1) * REG_EVERY < SHAMT_W) ? (g + 1) * REG_EVERY : SHAMT_W;
    localparam int N  = K1 - K0;

    // w_sh holds only the shamt bits not yet consumed by earlier groups.
    logic [SHAMT_W-K0-1:0] w_sh;
    op_e                   w_op;
    logic                  w_fill;
    logic [TAG_W-1:0]      w_tag;
    logic [N:0][WIDTH-1:0] w_d;
    logic [WIDTH-1:0]      r_data;
    logic [TAG_W-1:0]      r_tag;
`ifdef BSHIFT_STICKY_EN
    logic [N:0]            w_s;
    logic                  r_stk;
`endif

    if (g == 0) begin : src_in
      assign w_sh   = in_shamt;
      assign w_op   = op_e'(in_op);
      assign w_fill = in_data[WIDTH-1];
      assign w_tag  = in_tag;
      assign w_d[0] = in_data;
`ifdef BSHIFT_STICKY_EN
      assign w_s[0] = 1'b0;
`endif
    end else begin : src_reg
      assign w_sh   = grp[g-1].ctl.r_sh;
      assign w_op   = grp[g-1].ctl.r_op;
      assign w_fill = grp[g-1].ctl.r_fill;
      assign w_tag  = grp[g-1].r_tag;
      assign w_d[0] = grp[g-1].r_data;
`ifdef BSHIFT_STICKY_EN
      assign w_s[0] = grp[g-1].r_stk;
`endif
    end

    for (genvar j = 0; j < N; j++) begin : stg
`ifdef BSHIFT_STICKY_EN
      logic w_lost;
      assign w_s[j+1] = w_s[j] || w_lost;
`endif
      bshift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << (K0 + j))
      ) u_stage (
        .i_data   (w_d[j]),
        .i_fill   (w_fill),
        .i_en     (w_sh[j]),
        .i_op     (w_op),
        .o_data   (w_d[j+1])
`ifdef BSHIFT_STICKY_EN
        ,
        .o_sticky (w_lost)
`endif
      );
    end

    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_data <= '0;
        r_tag  <= '0;
`ifdef BSHIFT_STICKY_EN
        r_stk  <= 1'b0;
`endif
      end else if (w_adv) begin
        r_data <= w_d[N];
        r_tag  <= w_tag;
`ifdef BSHIFT_STICKY_EN
        r_stk  <= w_s[N];
`endif
      end

    // Control only needs to travel to groups that still have mux levels.
    if (g < L - 1) begin : ctl
      logic [SHAMT_W-K1-1:0] r_sh;
      op_e                   r_op;
      logic                  r_fill;

      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          r_sh   <= '0;
          r_op   <= OP_SLL;
          r_fill <= 1'b0;
        end else if (w_adv) begin
          r_sh   <= w_sh[SHAMT_W-K0-1:N];
          r_op   <= w_op;
          r_fill <= w_fill;
        end
    end
  end

  assign out_valid  = vld_pipe[L];
  assign out_data   = grp[L-1].r_data;
  assign out_tag    = grp[L-1].r_tag;
`ifdef BSHIFT_STICKY_EN
  assign out_sticky = grp[L-1].r_stk;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vectors, stall, reset,
// random traffic vs an arithmetic model, plus a 64-bit / REG_EVERY=5 instance.
module tb_barrel_shift_pipe;

  localparam int W = 32, SW = 5, TW = 4, LAT = 5;
  localparam int AW = 64, ASW = 6, ALAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_fail = 0, cyc = 0;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_sticky;

  logic           a_in_valid, a_in_ready, a_out_valid;
  logic [AW-1:0]  a_in_data, a_out_data;
  logic [ASW-1:0] a_in_shamt;
  logic [1:0]     a_in_op;
  logic [TW-1:0]  a_in_tag, a_out_tag;
  logic           a_out_sticky;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrel_shift_pipe #(.WIDTH(W), .REG_EVERY(1), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef BSHIFT_STICKY_EN
    , .out_sticky(out_sticky)
`endif
  );

  barrel_shift_pipe #(.WIDTH(AW), .REG_EVERY(5), .TAG_W(TW)) u_alt (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(1'b1), .out_data(a_out_data), .out_tag(a_out_tag)
`ifdef BSHIFT_STICKY_EN
    , .out_sticky(a_out_sticky)
`endif
  );

`ifndef BSHIFT_STICKY_EN
  assign out_sticky   = 1'b0;
  assign a_out_sticky = 1'b0;
`endif

  // Reference model: plain shifts on a 64-bit container masked to w bits.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s,
                                            input logic [1:0] op, input int w);
    logic [63:0] m;
    m = {64{1'b1}} >> (64 - w);
    d = d & m;
    if (s == 0) return d;
    case (op)
      2'b00:   return (d << s) & m;
      2'b01:   return d >> s;
      2'b10:   return d[w-1] ? ((d >> s) | (m & ~(m >> s))) : (d >> s);
      default: return ((d >> s) | (d << (w - s))) & m;
    endcase
  endfunction

  function automatic logic ref_sticky(input logic [63:0] d, input int s,
                                      input logic [1:0] op, input int w);
    logic [63:0] m;
    m = {64{1'b1}} >> (64 - w);
    d = d & m;
    if (s == 0 || op == 2'b11) return 1'b0;
    if (op == 2'b00) return (d >> (w - s)) != 0;
    return (d & ((64'd1 << s) - 64'd1)) != 0;
  endfunction

  task automatic test_reset();
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_chk++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
    n_chk++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_alt_valid got %b want 0", a_out_valid); end
`ifdef BSHIFT_STICKY_EN
    n_chk++; if (out_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", out_sticky); end
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    int          sh   [8] = '{4, 2, 3, 10, 0, 0, 0, 0};
    logic [31:0] exp  [8] = '{32'h69759710, 32'h35A5D65C, 32'hFAD2EB2E, 32'h5C75A5D6,
                              32'hD6975971, 32'hD6975971, 32'hD6975971, 32'hD6975971};
    logic        stk  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int t0;
    logic seen;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'hD6975971; in_op = ops[i];
      in_shamt = SW'(sh[i]); in_tag = TW'(i);
      t0 = cyc;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid) seen = 1'b1;
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL dir%0d_timeout no out_valid within 20 cycles", i); end
      n_chk++; if (cyc - t0 != LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc - t0, LAT); end
      n_chk++; if (out_data !== exp[i]) begin n_fail++; $display("FAIL dir%0d_data got %h want %h", i, out_data, exp[i]); end
      n_chk++; if (out_tag !== TW'(i)) begin n_fail++; $display("FAIL dir%0d_tag got %h want %h", i, out_tag, i); end
`ifdef BSHIFT_STICKY_EN
      n_chk++; if (out_sticky !== stk[i]) begin n_fail++; $display("FAIL dir%0d_sticky got %b want %b", i, out_sticky, stk[i]); end
`endif
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [8];
    logic [1:0]  op  [8];
    int          sh  [8];
    logic [31:0] exp_q [$];
    logic [31:0] snap_d, e;
    logic [TW-1:0] snap_t;
    int got = 0, sent = 0, phase = 0, stall = 0;
    for (int i = 0; i < 8; i++) begin
      dat[i] = $urandom; op[i] = 2'($urandom_range(0, 3)); sh[i] = $urandom_range(0, W - 1);
    end
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      out_ready = (phase != 1);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = dat[sent]; in_op = op[sent]; in_shamt = SW'(sh[sent]); in_tag = TW'(sent);
      end
      #1;
      if (phase == 1) begin
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready got %b want 0", in_ready); end
        if (stall == 0) begin
          snap_d = out_data; snap_t = out_tag;
        end else begin
          n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_valid got %b want 1", out_valid); end
          n_chk++; if (out_data !== snap_d) begin n_fail++; $display("FAIL b2b_hold_data got %h want %h", out_data, snap_d); end
          n_chk++; if (out_tag !== snap_t) begin n_fail++; $display("FAIL b2b_hold_tag got %h want %h", out_tag, snap_t); end
        end
        stall++;
        if (stall == 6) phase = 2;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_chk++; if (out_tag !== TW'(got)) begin n_fail++; $display("FAIL b2b_order got tag %h want %h", out_tag, got); end
        n_chk++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data got %h want %h", out_data, e); end
        got++;
        if (phase == 0) phase = 1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(32'(ref_shift(64'(dat[sent]), sh[sent], op[sent], W)));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_chk++; if (got != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", got); end
    n_chk++; if (stall != 6) begin n_fail++; $display("FAIL b2b_stall_seen got %0d want 6", stall); end
    repeat (3) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    int t0, seen;
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; in_op = 2'($urandom_range(0, 3));
      in_shamt = SW'($urandom_range(0, W - 1)); in_tag = TW'(i + 4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_chk++; if (seen != 1) begin n_fail++; $display("FAIL mid_reset_fill no out_valid before reset"); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_async_valid got %b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_in_ready got %b want 0", in_ready); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", out_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL mid_reset_stale got %0d results want 0", seen); end
    d = $urandom;
    in_valid = 1'b1; in_data = d; in_op = 2'b10; in_shamt = 5'd7; in_tag = 4'hA;
    t0 = cyc;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) seen = 1;
    end
    n_chk++; if (cyc - t0 != LAT || seen != 1) begin n_fail++; $display("FAIL mid_reset_latency got %0d want %0d", cyc - t0, LAT); end
    n_chk++; if (out_data !== 32'(ref_shift(64'(d), 7, 2'b10, W))) begin
      n_fail++; $display("FAIL mid_reset_data_new got %h want %h", out_data, 32'(ref_shift(64'(d), 7, 2'b10, W)));
    end
    @(negedge clk);
  endtask

  typedef struct { logic [63:0] d; logic [TW-1:0] t; logic s; int c; } exp_t;

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    logic hold = 1'b0;
    logic [31:0] snap_d;
    logic [TW-1:0] snap_t;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom; in_op = 2'($urandom_range(0, 3));
      in_shamt  = SW'($urandom_range(0, W - 1)); in_tag = TW'($urandom);
      #1;
      if (hold) begin
        n_chk++; if (out_valid !== 1'b1 || out_data !== snap_d || out_tag !== snap_t) begin
          n_fail++; $display("FAIL rnd_stable got %b/%h/%h want 1/%h/%h", out_valid, out_data, out_tag, snap_d, snap_t);
        end
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious result %h with empty model", out_data); end
        else begin
          e = q.pop_front();
          if (out_data !== e.d[31:0] || out_tag !== e.t || (out_sticky !== e.s && `ifdef BSHIFT_STICKY_EN 1'b1 `else 1'b0 `endif)) begin
            n_fail++; $display("FAIL rnd_result got %h/%h/%b want %h/%h/%b", out_data, out_tag, out_sticky, e.d[31:0], e.t, e.s);
          end
        end
      end
      hold = out_valid && !out_ready;
      snap_d = out_data; snap_t = out_tag;
      if (in_valid && in_ready) begin
        e.d = ref_shift(64'(in_data), int'(in_shamt), in_op, W);
        e.s = ref_sticky(64'(in_data), int'(in_shamt), in_op, W);
        e.t = in_tag; e.c = cyc;
        q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        n_chk++; if (out_data !== e.d[31:0] || out_tag !== e.t) begin
          n_fail++; $display("FAIL rnd_drain got %h/%h want %h/%h", out_data, out_tag, e.d[31:0], e.t);
        end
      end
      @(negedge clk);
    end
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_left got %0d pending want 0", q.size()); end
  endtask

  task automatic test_alt_width();
    exp_t q [$];
    exp_t e;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      a_in_valid = (c < 140) && ($urandom_range(0, 3) != 0);
      a_in_data  = {$urandom, $urandom}; a_in_op = 2'($urandom_range(0, 3));
      a_in_shamt = ASW'($urandom_range(0, AW - 1)); a_in_tag = TW'($urandom);
      #1;
      if (a_out_valid) begin
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL alt_spurious result %h", a_out_data); end
        else begin
          e = q.pop_front();
          if (a_out_data !== e.d || a_out_tag !== e.t || cyc - e.c != ALAT ||
              (a_out_sticky !== e.s && `ifdef BSHIFT_STICKY_EN 1'b1 `else 1'b0 `endif)) begin
            n_fail++; $display("FAIL alt_result got %h/%h/%b lat %0d want %h/%h/%b lat %0d",
                               a_out_data, a_out_tag, a_out_sticky, cyc - e.c, e.d, e.t, e.s, ALAT);
          end
        end
      end
      if (a_in_valid && a_in_ready) begin
        e.d = ref_shift(a_in_data, int'(a_in_shamt), a_in_op, AW);
        e.s = ref_sticky(a_in_data, int'(a_in_shamt), a_in_op, AW);
        e.t = a_in_tag; e.c = cyc;
        q.push_back(e);
      end
    end
    n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL alt_left got %0d pending want 0", q.size()); end
    a_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    test_alt_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
